// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_e;
endpackage

// File: rtl/nonrestoring_step.sv
// One radix-2 non-restoring iteration on a WIDTH+1 bit signed partial remainder.
module nonrestoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] rem,
  input  logic           qin,
  input  logic [WIDTH:0] babs,
  output logic [WIDTH:0] rem_nxt,
  output logic           qbit
);
  // One extra bit of headroom so 2*rem +/- |B| cannot wrap before the sign test.
  logic [WIDTH+1:0] shifted, bext, res;

  assign shifted = {rem, qin};
  assign bext    = {1'b0, babs};
  assign res     = rem[WIDTH] ? shifted + bext : shifted - bext;
  assign rem_nxt = res[WIDTH:0];
  assign qbit    = ~res[WIDTH+1];
endmodule

// File: rtl/booth_inverse_divider.sv
// Signed WIDTH-bit divider, one quotient bit per clock; done pulses WIDTH+1 cycles after start.
module booth_inverse_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic [WIDTH-1:0] outQuotient,
  output logic [WIDTH-1:0] outRemainder,
  output logic             done,
  output logic             busy,
  output logic             divByZero
);
  localparam int CW = $clog2(WIDTH);

  div_state_e       state, state_nxt;
  logic [WIDTH:0]   rem, babs, rem_nxt;
  logic [WIDTH-1:0] quo, a_mag, b_mag, r_mag;
  logic [CW-1:0]    cnt;
  logic             neg_a, neg_q, bzero, qbit;

  // Unsigned W-bit negation keeps |-2^(W-1)| exact.
  assign a_mag = inputA[WIDTH-1] ? -inputA : inputA;
  assign b_mag = inputB[WIDTH-1] ? -inputB : inputB;
  assign busy  = (state != IDLE);

  nonrestoring_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .qin     (quo[WIDTH-1]),
    .babs    (babs),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  // Final remainder correction; the result is always below |B| so W bits suffice.
  assign r_mag = rem[WIDTH] ? rem[WIDTH-1:0] + babs[WIDTH-1:0] : rem[WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem          <= '0;
      babs         <= '0;
      quo          <= '0;
      cnt          <= '0;
      neg_a        <= 1'b0;
      neg_q        <= 1'b0;
      bzero        <= 1'b0;
      outQuotient  <= '0;
      outRemainder <= '0;
      done         <= 1'b0;
      divByZero    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          quo   <= a_mag;
          babs  <= {1'b0, b_mag};
          rem   <= '0;
          neg_a <= inputA[WIDTH-1];
          neg_q <= inputA[WIDTH-1] ^ inputB[WIDTH-1];
          bzero <= (inputB == '0);
          cnt   <= CW'(WIDTH - 1);
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= {quo[WIDTH-2:0], qbit};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          // With |B| = 0 the iteration leaves |A| in the remainder, so R = A falls out naturally.
          outQuotient  <= bzero ? '1 : (neg_q ? -quo : quo);
          outRemainder <= neg_a ? -r_mag : r_mag;
          divByZero    <= bzero;
          done         <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
